seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed seven-segment scan controller for the board display.
- Takes a packed word of hex nibbles and produces, per digit slot:
  - a 7-bit segment pattern (seg),
  - an output-enable (seg_oe),
  - active-low anode selects (an).
- Sits directly upstream of the 7-bit tri-state segment buffer: seg drives the buffer's data input, seg_oe drives its enable.
- Inserts a blanking gap at every digit switch to suppress ghosting.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 2, leading cycles of each slot with seg_oe low and all anodes off (1 <= BLANK_CYCLES < SCAN_DIV).
- SEG_ACTIVE_LOW, 1, 1 = segment bit 0 lights the segment; 0 = segment bit 1 lights it.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- data  input  4*DIGITS  hex nibbles; digit k = data[4k+3:4k], digit 0 rightmost.
- digit_en  input  DIGITS  per-digit enable; 0 = digit stays dark.
- dp  input  DIGITS  per-digit decimal point request.
- seg  output  7  segment pattern {g,f,e,d,c,b,a}, bit0 = a; to tri-state buffer input.
- seg_oe  output  1  buffer enable; high only while a digit is displayed.
- dp_out  output  1  decimal point, same polarity as seg.
- an  output  DIGITS  anode selects, active-low, one-hot-low when showing.
- frame_tick  output  1  one-cycle pulse on the first output cycle of slot 0.

Behaviour:
- Reset values (one edge after rst high):
  - seg = SEG_OFF (7'h7F if SEG_ACTIVE_LOW else 7'h00), dp_out = off.
  - seg_oe = 0, an = all 1s, frame_tick = 0.
  - Internal: presc = 0, idx = 0, state = BLANK, snapshot registers = 0.
- Reset mid-operation behaves the same way: next edge forces reset values and the scan restarts at slot 0.
- Counters:
  - presc counts 0..SCAN_DIV-1 and then wraps.
  - idx increments when presc wraps; it wraps from DIGITS-1 to 0.
  - idx width = max(1, clog2(DIGITS)).
- Frame snapshot:
  - data, digit_en and dp are captured into internal registers on every cycle where idx==0 && presc==0.
  - Changes elsewhere in a frame take effect at the next frame only (no tearing).
- State machine, two states:
  - BLANK while presc < BLANK_CYCLES.
  - SHOW while BLANK_CYCLES <= presc <= SCAN_DIV-1.
  - Transitions are purely counter-driven.
- Outputs are registered, one cycle after the internal state that generates them:
  - BLANK: seg_oe = 0, an = all 1s, seg = SEG_OFF, dp_out = off.
  - SHOW with snap_en[idx] = 1: seg = decode(snap_data[idx]), dp_out = snap_dp[idx] (polarity per SEG_ACTIVE_LOW), an[idx] = 0 (others 1), seg_oe = 1.
  - SHOW with snap_en[idx] = 0: identical to BLANK.
- Output timeline: the first output cycle of slot 0 is the 2nd rising edge after rst deasserts. Each slot then lasts exactly SCAN_DIV output cycles: BLANK_CYCLES blank cycles, then SCAN_DIV-BLANK_CYCLES showing cycles.
- frame_tick is high on exactly that first output cycle of slot 0, once per DIGITS*SCAN_DIV cycles.
- Decode is the standard hex font, active-high form:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07,
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
  - Inverted when SEG_ACTIVE_LOW = 1.
- Invariants:
  - seg_oe = 1 implies exactly one an bit is 0.
  - seg_oe = 0 implies an = all 1s.
  - Two anodes are never low in the same cycle.

Decomposition:
- Package seg7_pkg: SEG_OFF constants, the 16-entry font table, and the polarity-apply helper function.
- One sub-module, seg7_hex_decode: combinational, nibble + polarity to 7-bit pattern, reusable by other display paths.
- Counters, FSM and output registers stay in seg7_scan_driver.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=1.
1. Reset: hold rst 3 cycles, data = 16'h1234, digit_en = 4'hF.
   - During and one cycle after rst: seg = 7'h7F, seg_oe = 0, an = 4'hF, frame_tick = 0.
2. Normal scan: release rst with the same inputs.
   - frame_tick pulse.
   - Slot 0: 1 blank cycle, then 3 cycles with an = 4'b1110, seg = 7'b0011001 (4).
   - Slot 1: an = 4'b1101, seg = 7'b0110000 (3).
   - Slot 2: an = 4'b1011, seg = 7'b0100100 (2).
   - Slot 3: an = 4'b0111, seg = 7'b1111001 (1).
   - Period 16 cycles.
3. Mid-frame data change: switch data to 16'h8888 during slot 1.
   - Slots 2 and 3 still show 2 and 1.
   - The next frame shows seg = 7'b0000000 on all digits.
4. Digit disable and decimal point: digit_en = 4'b0101, dp = 4'b0001.
   - Slots 1 and 3 have seg_oe = 0 and an = 4'hF throughout.
   - Slot 0 has dp_out = 0 (lit); slot 2 has dp_out = 1.
5. Reset mid-slot: assert rst for 1 cycle during a SHOW cycle of slot 2.
   - Next edge gives reset values.
   - The scan restarts at slot 0, with frame_tick 2 edges after release.
6. Invariant check: random data, digit_en and dp over 1000 frames.
   - The seg_oe/an invariants are never violated.
   - The blank gap is exactly 1 cycle at every slot boundary.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank patterns, hex font and polarity handling.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF_ACTIVE_LOW  = 7'h7F;
    localparam logic [6:0] SEG_OFF_ACTIVE_HIGH = 7'h00;

    // Active-high font, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pat_hi, input bit active_low);
        return active_low ? ~pat_hi : pat_hi;
    endfunction

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to seven-segment pattern decoder with selectable polarity.
module seg7_hex_decode #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    import seg7_pkg::*;

    always_comb begin
        seg_o = seg_polarity(HEX_FONT[nibble_i], ACTIVE_LOW);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan controller with per-slot blanking gap and
// frame-synchronous input snapshot.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  seg_oe,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    import seg7_pkg::*;

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_LIM  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [6:0]         SEG_OFF    = seg_off(SEG_ACTIVE_LOW);
    localparam logic               DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic               DP_ON      = !SEG_ACTIVE_LOW;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Counter stage
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               frame_start;

    // Frame snapshot
    logic [4*DIGITS-1:0] snap_data_q;
    logic [DIGITS-1:0]   snap_en_q;
    logic [DIGITS-1:0]   snap_dp_q;

    // State stage, one cycle behind the counters
    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   st_idx_q, st_idx_d;
    logic               st_first_q, st_first_d;

    // Output stage
    logic [6:0]         seg_q, seg_d;
    logic               seg_oe_q, seg_oe_d;
    logic               dp_out_q, dp_out_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic               frame_tick_q, frame_tick_d;

    logic [3:0]         cur_nib;
    logic               cur_en;
    logic               cur_dp;
    logic [DIGITS-1:0]  cur_an;
    logic [6:0]         cur_seg;

    always_comb begin
        presc_d     = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        idx_d       = idx_q;
        if (presc_q == PRESC_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        frame_start = (presc_q == '0) && (idx_q == '0);
        state_d     = (presc_q < BLANK_LIM) ? ST_BLANK : ST_SHOW;
        st_idx_d    = idx_q;
        st_first_d  = frame_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            state_q    <= ST_BLANK;
            st_idx_q   <= '0;
            st_first_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            st_idx_q   <= st_idx_d;
            st_first_q <= st_first_d;
        end
    end

    // Captured on the same edge that loads the slot-0 blank state, so the last
    // output cycle of the previous frame still reads the old snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_data_q <= '0;
            snap_en_q   <= '0;
            snap_dp_q   <= '0;
        end else if (frame_start) begin
            snap_data_q <= data;
            snap_en_q   <= digit_en;
            snap_dp_q   <= dp;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_an  = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (st_idx_q == IDX_W'(k)) begin
                cur_nib   = snap_data_q[4*k +: 4];
                cur_en    = snap_en_q[k];
                cur_dp    = snap_dp_q[k];
                cur_an[k] = 1'b0;
            end
        end
    end

    seg7_hex_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    always_comb begin
        seg_d        = SEG_OFF;
        dp_out_d     = DP_OFF;
        an_d         = '1;
        seg_oe_d     = 1'b0;
        frame_tick_d = st_first_q;
        if ((state_q == ST_SHOW) && cur_en) begin
            seg_d    = cur_seg;
            dp_out_d = cur_dp ? DP_ON : DP_OFF;
            an_d     = cur_an;
            seg_oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            an_q         <= '1;
            seg_oe_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            seg_oe_q     <= seg_oe_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign seg_oe     = seg_oe_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots, 1-cycle blank gap.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        seg_oe;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_tick;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS         (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .digit_en   (digit_en),
        .dp         (dp),
        .seg        (seg),
        .seg_oe     (seg_oe),
        .dp_out     (dp_out),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font_al(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic cyc(input string tag, input logic oe_e, input logic [3:0] an_e,
                       input logic [6:0] seg_e, input logic dp_e, input logic tick_e);
        @(negedge clk);
        chk({tag, "/oe"},   32'(seg_oe),     32'(oe_e));
        chk({tag, "/an"},   32'(an),         32'(an_e));
        chk({tag, "/seg"},  32'(seg),        32'(seg_e));
        chk({tag, "/dp"},   32'(dp_out),     32'(dp_e));
        chk({tag, "/tick"}, 32'(frame_tick), 32'(tick_e));
    endtask

    task automatic blank_cyc(input string tag, input logic tick_e);
        cyc(tag, 1'b0, 4'hF, 7'h7F, 1'b1, tick_e);
    endtask

    task automatic slot(input string tag, input int s, input logic on,
                        input logic [6:0] seg_e, input logic dp_e);
        logic [3:0] an_e;
        an_e    = 4'hF;
        an_e[s] = 1'b0;
        blank_cyc($sformatf("%s/s%0d/c0", tag, s), s == 0);
        for (int c = 1; c < 4; c++) begin
            if (on) cyc($sformatf("%s/s%0d/c%0d", tag, s, c), 1'b1, an_e, seg_e, dp_e, 1'b0);
            else    blank_cyc($sformatf("%s/s%0d/c%0d", tag, s, c), 1'b0);
        end
    endtask

    initial begin
        logic [15:0] d_cur, d_nxt;
        logic [3:0]  e_cur, e_nxt, p_cur, p_nxt;
        logic        inv_ok;
        logic [3:0]  an_e;

        // 1: reset held three cycles
        rst = 1'b1; data = 16'h1234; digit_en = 4'hF; dp = 4'h0;
        for (int i = 0; i < 3; i++) blank_cyc($sformatf("rst%0d", i), 1'b0);
        rst = 1'b0;
        blank_cyc("post_rst", 1'b0);

        // 2: normal scan, digit 0 rightmost
        slot("scan", 0, 1'b1, 7'b0011001, 1'b1);
        slot("scan", 1, 1'b1, 7'b0110000, 1'b1);
        slot("scan", 2, 1'b1, 7'b0100100, 1'b1);
        slot("scan", 3, 1'b1, 7'b1111001, 1'b1);

        // 3: data changed during slot 1 must not tear the current frame
        slot("tear", 0, 1'b1, 7'b0011001, 1'b1);
        data = 16'h8888;
        slot("tear", 1, 1'b1, 7'b0110000, 1'b1);
        slot("tear", 2, 1'b1, 7'b0100100, 1'b1);
        slot("tear", 3, 1'b1, 7'b1111001, 1'b1);
        slot("eights", 0, 1'b1, 7'h00, 1'b1);
        data = 16'h0F5A; digit_en = 4'b0101; dp = 4'b0001;
        slot("eights", 1, 1'b1, 7'h00, 1'b1);
        slot("eights", 2, 1'b1, 7'h00, 1'b1);
        slot("eights", 3, 1'b1, 7'h00, 1'b1);

        // 4: digits 1 and 3 dark, decimal point on digit 0 only
        slot("en_dp", 0, 1'b1, 7'h08, 1'b0);
        slot("en_dp", 1, 1'b0, 7'h7F, 1'b1);
        slot("en_dp", 2, 1'b1, 7'h0E, 1'b1);
        slot("en_dp", 3, 1'b0, 7'h7F, 1'b1);

        // 5: one-cycle reset during a show cycle of slot 2
        slot("mid", 0, 1'b1, 7'h08, 1'b0);
        slot("mid", 1, 1'b0, 7'h7F, 1'b1);
        blank_cyc("mid/s2/c0", 1'b0);
        cyc("mid/s2/c1", 1'b1, 4'b1011, 7'h0E, 1'b1, 1'b0);
        rst = 1'b1;
        blank_cyc("mid/rst", 1'b0);
        rst = 1'b0;
        blank_cyc("mid/rel", 1'b0);
        slot("restart", 0, 1'b1, 7'h08, 1'b0);
        slot("restart", 1, 1'b0, 7'h7F, 1'b1);
        slot("restart", 2, 1'b1, 7'h0E, 1'b1);
        slot("restart", 3, 1'b0, 7'h7F, 1'b1);

        // 6: random inputs, changed mid-frame so they land one frame later
        d_cur = data; e_cur = digit_en; p_cur = dp;
        d_nxt = d_cur; e_nxt = e_cur; p_nxt = p_cur;
        for (int f = 0; f < 1000; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    inv_ok = seg_oe ? ($countones(~an) == 1) : (an == 4'hF);
                    chk("inv", 32'(inv_ok), 32'd1);
                    an_e = 4'hF;
                    if (c != 0 && e_cur[s]) an_e[s] = 1'b0;
                    chk($sformatf("rnd/f%0d/s%0d/c%0d/oe", f, s, c), 32'(seg_oe),
                        32'(c != 0 && e_cur[s]));
                    chk($sformatf("rnd/f%0d/s%0d/c%0d/an", f, s, c), 32'(an), 32'(an_e));
                    chk($sformatf("rnd/f%0d/s%0d/c%0d/seg", f, s, c), 32'(seg),
                        32'((c != 0 && e_cur[s]) ? font_al(d_cur[4*s +: 4]) : 7'h7F));
                    chk($sformatf("rnd/f%0d/s%0d/c%0d/tick", f, s, c), 32'(frame_tick),
                        32'(s == 0 && c == 0));
                    if (s == 1 && c == 0) begin
                        d_nxt = 16'($urandom);
                        e_nxt = 4'($urandom_range(0, 15));
                        p_nxt = 4'($urandom_range(0, 15));
                        data = d_nxt; digit_en = e_nxt; dp = p_nxt;
                    end
                end
            end
            d_cur = d_nxt; e_cur = e_nxt; p_cur = p_nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
